// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP command queue: display-port register
// addresses, queue entry layout and drain FSM state encoding.
package bmp_pkg;

  localparam logic [15:0] BMP_ADDR_X    = 16'hC008;
  localparam logic [15:0] BMP_ADDR_Y    = 16'hC009;
  localparam logic [15:0] BMP_ADDR_CTRL = 16'hC00A;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned C_W     = 16;
  localparam int unsigned ENTRY_W = X_W + Y_W + C_W;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_X,
    ST_SEND_Y,
    ST_SEND_C,
    ST_GAP
  } state_t;

endpackage

// File: rtl/bmp_cmd_fifo.sv
// Synchronous FIFO for queued placement commands. DEPTH must be a power
// of two so the pointers wrap naturally. A pop frees a slot in the same
// clock, so push+pop while full is accepted.
module bmp_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/bmp_cmd_queue.sv
// BMP command queue: CPU posts X/Y/CTRL placement commands into a FIFO;
// a drain FSM replays each as a paced burst on the display bus port
// (C008 X, C009 Y, C00A control) followed by GAP_CYCLES idle clocks.
// Optional build macro BMP_Q_SKIP_DUP_XY_EN: omit X/Y beats that repeat
// the last issued value.
module bmp_cmd_queue
  import bmp_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [15:0] BASE_ADDR  = 16'hC010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        end_clear,
  input  logic        place_busy,
  output logic        bmp_sel,
  output logic [15:0] bmp_addr,
  output logic [15:0] bmp_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [X_W-1:0] r_stage_x;
  logic [Y_W-1:0] r_stage_y;
  logic           r_ovf;
  state_t         r_state;
  entry_t         r_iss;
  logic           r_skip_y;
  logic [GW-1:0]  r_gap;
  logic           r_sel;
  logic [15:0]    r_addr;
  logic [15:0]    r_data;

  logic               w_wr_x, w_wr_y, w_wr_c, w_wr_clr;
  logic               w_pop, w_full, w_empty;
  logic [CW-1:0]      w_count;
  logic [ENTRY_W-1:0] w_head_bits;
  entry_t             w_head;
  entry_t             w_push_entry;
  logic [15:0]        w_status;
  logic               w_skip_x, w_skip_y;

  assign w_wr_x   = cpu_we && (cpu_addr == BASE_ADDR);
  assign w_wr_y   = cpu_we && (cpu_addr == BASE_ADDR + 16'd1);
  assign w_wr_c   = cpu_we && (cpu_addr == BASE_ADDR + 16'd2);
  assign w_wr_clr = cpu_we && (cpu_addr == BASE_ADDR + 16'd3);

  assign w_push_entry = '{x: r_stage_x, y: r_stage_y, ctrl: cpu_wdata};
  assign w_head       = entry_t'(w_head_bits);
  assign w_pop        = (r_state == ST_IDLE) && !w_empty && end_clear && !place_busy;

  assign w_status  = {r_ovf, w_full, w_empty, 8'h00, 5'(w_count)};
  assign cpu_rdata = (cpu_addr == BASE_ADDR + 16'd3) ? w_status : '0;

  assign bmp_sel  = r_sel;
  assign bmp_addr = r_addr;
  assign bmp_data = r_data;

  bmp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_c),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // CPU-side staging registers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_x <= '0;
      r_stage_y <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_x) r_stage_x <= cpu_wdata[X_W-1:0];
      if (w_wr_y) r_stage_y <= cpu_wdata[Y_W-1:0];
      if (w_wr_c && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_clr)              r_ovf <= 1'b0;
    end
  end

`ifdef BMP_Q_SKIP_DUP_XY_EN
  logic [X_W-1:0] r_last_x;
  logic [Y_W-1:0] r_last_y;
  logic           r_last_v;

  // Remember the coordinates of the most recently issued command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_x <= '0;
      r_last_y <= '0;
      r_last_v <= 1'b0;
    end else if (w_pop) begin
      r_last_x <= w_head.x;
      r_last_y <= w_head.y;
      r_last_v <= 1'b1;
    end
  end
`endif

  // Decide which coordinate beats of the head entry are redundant.
  always_comb begin
    w_skip_x = 1'b0;
    w_skip_y = 1'b0;
`ifdef BMP_Q_SKIP_DUP_XY_EN
    w_skip_x = r_last_v && (w_head.x == r_last_x);
    w_skip_y = r_last_v && (w_head.y == r_last_y);
`endif
  end

  // Drain FSM: pop in IDLE, emit one registered beat per SEND state, then pace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_iss    <= '0;
      r_skip_y <= 1'b0;
      r_gap    <= '0;
      r_sel    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel  <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
          if (w_pop) begin
            r_iss    <= w_head;
            r_skip_y <= w_skip_y;
            if (!w_skip_x)      r_state <= ST_SEND_X;
            else if (!w_skip_y) r_state <= ST_SEND_Y;
            else                r_state <= ST_SEND_C;
          end
        end
        ST_SEND_X: begin
          r_sel   <= 1'b1;
          r_addr  <= BMP_ADDR_X;
          r_data  <= {6'h00, r_iss.x};
          r_state <= r_skip_y ? ST_SEND_C : ST_SEND_Y;
        end
        ST_SEND_Y: begin
          r_sel   <= 1'b1;
          r_addr  <= BMP_ADDR_Y;
          r_data  <= {7'h00, r_iss.y};
          r_state <= ST_SEND_C;
        end
        ST_SEND_C: begin
          r_sel   <= 1'b1;
          r_addr  <= BMP_ADDR_CTRL;
          r_data  <= r_iss.ctrl;
          r_gap   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          r_sel  <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
          if (r_gap == GAP_LAST) r_state <= ST_IDLE;
          else                   r_gap   <= r_gap + GW'(1);
        end
        default: begin
          r_sel   <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_cmd_queue.sv
// Self-checking bench for bmp_cmd_queue: table-driven command vectors,
// a beat scoreboard fed at push time, and hand sequences for timing,
// overflow, place_busy hold and mid-burst reset.
module tb_bmp_cmd_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 16;
  localparam logic [15:0] BASE  = 16'hC010;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        end_clear;
  logic        place_busy;
  logic        bmp_sel;
  logic [15:0] bmp_addr;
  logic [15:0] bmp_data;

  bmp_cmd_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .end_clear  (end_clear),
    .place_busy (place_busy),
    .bmp_sel    (bmp_sel),
    .bmp_addr   (bmp_addr),
    .bmp_data   (bmp_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic [15:0] wx;
    logic [15:0] wy;
    logic [15:0] wc;
    logic [15:0] ex;
    logic [15:0] ey;
  } vec_t;

  beat_t       sb[$];
  int unsigned beat_cyc[$];
  int          n_chk   = 0;
  int          n_fail  = 0;
  int          n_beats = 0;
  beat_t       mon_e;

  logic [15:0] st_x = '0;
  logic [15:0] st_y = '0;
  logic [15:0] m_x  = '0;
  logic [15:0] m_y  = '0;
  bit          m_v  = 1'b0;
  int unsigned push_cyc;

  // Beat monitor: every selected beat must match the scoreboard head; idle is all-zero.
  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (bmp_sel) begin
        n_beats++;
        beat_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got addr 0x%04h data 0x%04h, expected no beat",
                   bmp_addr, bmp_data);
        end else begin
          mon_e = sb.pop_front();
          if (bmp_addr !== mon_e.addr || bmp_data !== mon_e.data) begin
            n_fail++;
            $display("FAIL beat: got addr 0x%04h data 0x%04h, expected addr 0x%04h data 0x%04h",
                     bmp_addr, bmp_data, mon_e.addr, mon_e.data);
          end
        end
      end else if (bmp_addr !== 16'h0 || bmp_data !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_bus: got addr 0x%04h data 0x%04h, expected 0x0000/0x0000",
                 bmp_addr, bmp_data);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected beats for one accepted command, in issue order.
  task automatic model_issue(input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] c);
`ifdef BMP_Q_SKIP_DUP_XY_EN
    if (!(m_v && ex == m_x)) sb.push_back('{16'hC008, ex});
    if (!(m_v && ey == m_y)) sb.push_back('{16'hC009, ey});
`else
    sb.push_back('{16'hC008, ex});
    sb.push_back('{16'hC009, ey});
`endif
    sb.push_back('{16'hC00A, c});
    m_x = ex;
    m_y = ey;
    m_v = 1'b1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    @(posedge clk);
    #1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0;
  endtask

  task automatic wr_x(input logic [15:0] d);
    cpu_wr(BASE, d);
    st_x = {6'h00, d[9:0]};
  endtask

  task automatic wr_y(input logic [15:0] d);
    cpu_wr(BASE + 16'd1, d);
    st_y = {7'h00, d[8:0]};
  endtask

  task automatic push(input logic [15:0] c, input bit accept);
    cpu_wr(BASE + 16'd2, c);
    push_cyc = cyc;
    if (accept) model_issue(st_x, st_y, c);
  endtask

  task automatic rd_status(input string nm, input logic [15:0] exp);
    @(negedge clk);
    cpu_addr = BASE + 16'd3;
    #1;
    check(nm, {16'h0, cpu_rdata}, {16'h0, exp});
    cpu_addr = 16'h0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check(nm, sb.size(), 0);
  endtask

  task automatic wait_sel(input string nm, input int budget);
    int i;
    bit seen;
    seen = 1'b0;
    for (i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bmp_sel) seen = 1'b1;
    end
    check(nm, seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tv[6];
  int   b0;
  int   s0;
  int   held_exp;

  initial begin
    tv[0] = '{16'h0123, 16'h0045, 16'h1111, 16'h0123, 16'h0045};
    tv[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h03FF, 16'h01FF};
    tv[2] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};
    tv[3] = '{16'hFD40, 16'hFEF0, 16'h00A5, 16'h0140, 16'h00F0};
    tv[4] = '{16'h0200, 16'h0100, 16'h5A5A, 16'h0200, 16'h0100};
    tv[5] = '{16'h0001, 16'h0002, 16'hC3C3, 16'h0001, 16'h0002};

    rst_n      = 1'b0;
    cpu_addr   = BASE + 16'd3;
    cpu_we     = 1'b0;
    cpu_wdata  = 16'h0;
    end_clear  = 1'b1;
    place_busy = 1'b0;
    #5;
    check("rst_sel", {31'h0, bmp_sel}, 0);
    check("rst_addr", {16'h0, bmp_addr}, 0);
    check("rst_data", {16'h0, bmp_data}, 0);
    check("rst_status", {16'h0, cpu_rdata}, 32'h2000);
    cpu_addr = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: single command, beat latency and spacing, then quiet gap
    wr_x(16'h0140);
    wr_y(16'h00F0);
    beat_cyc.delete();
    push(16'h0007, 1'b1);
    wait_drain("t1_drain", 20);
    check("t1_nbeats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) begin
      check("t1_lat_x", beat_cyc[0] - push_cyc, 2);
      check("t1_lat_y", beat_cyc[1] - push_cyc, 3);
      check("t1_lat_c", beat_cyc[2] - push_cyc, 4);
    end
    b0 = n_beats;
    repeat (18) @(negedge clk);
    check("t1_gap_quiet", n_beats, b0);

    // 2: hold with end_clear low, then drain in FIFO order with pacing
    end_clear = 1'b0;
    b0 = n_beats;
    for (int i = 0; i < 3; i++) begin
      wr_x(tv[i].wx);
      wr_y(tv[i].wy);
      cpu_wr(BASE + 16'd2, tv[i].wc);
      model_issue(tv[i].ex, tv[i].ey, tv[i].wc);
    end
    repeat (10) @(negedge clk);
    check("t2_held", n_beats, b0);
    rd_status("t2_status_cnt3", 16'h0003);
    beat_cyc.delete();
    end_clear = 1'b1;
    wait_drain("t2_drain", 200);
    check("t2_nbeats", beat_cyc.size(), 9);
    if (beat_cyc.size() == 9) begin
      check("t2_beat_adj", beat_cyc[1] - beat_cyc[0], 1);
      check("t2_gap_1_2", beat_cyc[3] - beat_cyc[2], GAP + 2);
      check("t2_gap_2_3", beat_cyc[6] - beat_cyc[5], GAP + 2);
    end

    // remaining table vectors, posted back to back
    for (int i = 3; i < 6; i++) begin
      wr_x(tv[i].wx);
      wr_y(tv[i].wy);
      cpu_wr(BASE + 16'd2, tv[i].wc);
      model_issue(tv[i].ex, tv[i].ey, tv[i].wc);
      st_x = tv[i].ex;
      st_y = tv[i].ey;
    end
    wait_drain("tv_drain", 300);

    // writes outside the window leave staged X/Y untouched
    cpu_wr(BASE + 16'd4, 16'h0155);
    cpu_wr(16'hC008, 16'h0166);
    cpu_wr(BASE - 16'd1, 16'h0177);
    push(16'h0E0E, 1'b1);
    wait_drain("ign_drain", 60);

    // 3: overflow, sticky flag, clear, push+pop while full
    place_busy = 1'b1;
    repeat (GAP + 4) @(negedge clk);
    for (int i = 0; i < 9; i++) push(16'h0300 + 16'(i), i < 8);
    rd_status("t3_status_ovf_full", 16'hC008);
    cpu_wr(BASE + 16'd3, 16'h0000);
    rd_status("t3_status_clr", 16'h4008);
    @(negedge clk);
    place_busy = 1'b0;
    cpu_addr   = BASE + 16'd2;
    cpu_wdata  = 16'h0BEE;
    cpu_we     = 1'b1;
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    model_issue(st_x, st_y, 16'h0BEE);
    cpu_addr = BASE + 16'd3;
    #1;
    check("t3_pushpop_full", {16'h0, cpu_rdata}, 32'h4008);
    cpu_addr = 16'h0;
    wait_drain("t3_drain", 9 * (GAP + 6));

    // 4: place_busy mid-burst does not stop it; next burst waits
    place_busy = 1'b1;
    wr_x(16'h0011);
    wr_y(16'h0022);
    push(16'h0101, 1'b1);
    wr_x(16'h0033);
    s0 = sb.size();
    push(16'h0202, 1'b1);
    held_exp = sb.size() - s0;
    repeat (GAP + 4) @(negedge clk);
    place_busy = 1'b0;
    wait_sel("t4_first_beat", 30);
    place_busy = 1'b1;
    repeat (GAP + 20) @(negedge clk);
    check("t4_held_beats", sb.size(), held_exp);
    rd_status("t4_status_cnt1", 16'h0001);
    place_busy = 1'b0;
    wait_drain("t4_drain", 60);

    // 5: reset during a burst
    place_busy = 1'b1;
    wr_x(16'h0044);
    push(16'h0303, 1'b1);
    push(16'h0404, 1'b1);
    repeat (GAP + 4) @(negedge clk);
    place_busy = 1'b0;
    wait_sel("t5_first_beat", 30);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sel", {31'h0, bmp_sel}, 0);
    check("t5_rst_addr", {16'h0, bmp_addr}, 0);
    check("t5_rst_data", {16'h0, bmp_data}, 0);
    sb.delete();
    m_v  = 1'b0;
    st_x = '0;
    st_y = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_status("t5_status_empty", 16'h2000);
    repeat (10) @(negedge clk);

    // 6: repeated X/Y
    wr_x(16'h0005);
    wr_y(16'h0006);
    b0 = n_beats;
    push(16'h0001, 1'b1);
    push(16'h0002, 1'b1);
    wait_drain("t6_drain", 80);
`ifdef BMP_Q_SKIP_DUP_XY_EN
    check("t6_nbeats", n_beats - b0, 4);
`else
    check("t6_nbeats", n_beats - b0, 6);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
